// File: rtl/ps2_pkg.sv
// Shared constants, types and helpers for the PS/2 set-2 scancode decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_E1 = 8'hE1;

    // Keyboard control/response bytes: ACK, BAT ok, resend, echo, errors
    localparam int N_CTL = 6;
    localparam logic [7:0] PS2_CTL_BYTES [N_CTL] = '{8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    // Make+break byte stream the keyboard emits for the Pause key
    localparam logic [7:0] PAUSE_SEQ [0:7] = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                                               8'hF0, 8'h14, 8'hF0, 8'h77};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_GAP  = 2'd2
    } byte_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic       pause;
    } ps2_evt_t;

    // True when b is one of the keyboard control bytes
    function automatic logic is_ctl_byte(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_CTL; i++) begin
            if (b == PS2_CTL_BYTES[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Error bytes also flush any pending prefix state
    function automatic logic is_err_ctl_byte(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Small synchronous event FIFO with show-ahead head output and sticky overflow.
// Pop is resolved before push, so a full FIFO accepts a push when it is popped
// in the same cycle.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             do_pop, do_push;
    logic             full, empty;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // Pop first; a push then fits if there was room or the pop made room
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    // Pointer, occupancy and overflow next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (push_i && !do_push) begin
            ovf_d = 1'b1;
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents need no reset because empty gates the output
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Show-ahead head: the consumer sees the oldest entry without a read cycle
    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
    assign full_o  = full;
    assign empty_o = empty;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scancode decoder: consumes receiver bytes, resolves F0/E0
// prefixes and the E1 Pause sequence, flags control bytes and queues key events.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PAUSE_EN   = 1,
    parameter int DROP_CTL   = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] psCode,
    input  logic       dRdy,
    output logic       clrDrdy,
    output logic [7:0] evCode,
    output logic       evBreak,
    output logic       evExt,
    output logic       evPause,
    output logic       evValid,
    input  logic       evReady,
    output logic       ctlSeen,
    output logic       seqErr,
    output logic       ovf
);

    byte_state_t state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic        brk_q, brk_d;
    logic        ext_q, ext_d;
    logic [2:0]  pidx_q, pidx_d;
    logic        push_q, push_d;
    ps2_evt_t    evt_q, evt_d;
    logic        ctl_q, ctl_d;
    logic        err_q, err_d;

    ps2_evt_t    head;
    logic        fifo_empty;

    // Byte handshake FSM: latch, acknowledge, then give the receiver a cycle to drop dRdy
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        clrDrdy = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dRdy) begin
                    byte_d  = psCode;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                clrDrdy = 1'b1;
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte decode in the acknowledge cycle; results are registered for one cycle
    always_comb begin
        brk_d  = brk_q;
        ext_d  = ext_q;
        pidx_d = pidx_q;
        push_d = 1'b0;
        evt_d  = '0;
        ctl_d  = 1'b0;
        err_d  = 1'b0;
        if (state_q == S_ACK) begin
            if ((PAUSE_EN != 0) && (pidx_q != 3'd0)) begin
                // Inside the Pause sequence every byte must follow the fixed pattern
                if (byte_q == PAUSE_SEQ[pidx_q]) begin
                    if (pidx_q == 3'd7) begin
                        push_d = 1'b1;
                        evt_d  = '{code: PS2_E1, brk: 1'b0, ext: 1'b0, pause: 1'b1};
                        pidx_d = 3'd0;
                    end else begin
                        pidx_d = pidx_q + 3'd1;
                    end
                end else begin
                    pidx_d = 3'd0;
                    err_d  = 1'b1;
                end
            end else if ((PAUSE_EN != 0) && (byte_q == PS2_E1)) begin
                pidx_d = 3'd1;
                brk_d  = 1'b0;
                ext_d  = 1'b0;
            end else if (is_ctl_byte(byte_q)) begin
                ctl_d = 1'b1;
                if (DROP_CTL == 0) begin
                    // Queued like an ordinary code; error bytes carry no prefix
                    push_d = 1'b1;
                    if (is_err_ctl_byte(byte_q)) begin
                        evt_d = '{code: byte_q, brk: 1'b0, ext: 1'b0, pause: 1'b0};
                    end else begin
                        evt_d = '{code: byte_q, brk: brk_q, ext: ext_q, pause: 1'b0};
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else if (is_err_ctl_byte(byte_q)) begin
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
            end else if (byte_q == PS2_E0) begin
                // Extend must precede break; F0 E0 is a broken stream
                if (brk_q) begin
                    err_d = 1'b1;
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else begin
                    ext_d = 1'b1;
                end
            end else if (byte_q == PS2_F0) begin
                brk_d = 1'b1;
            end else begin
                push_d = 1'b1;
                evt_d  = '{code: byte_q, brk: brk_q, ext: ext_q, pause: 1'b0};
                brk_d  = 1'b0;
                ext_d  = 1'b0;
            end
        end
    end

    // Decoder state and registered pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            pidx_q  <= 3'd0;
            push_q  <= 1'b0;
            evt_q   <= '0;
            ctl_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            pidx_q  <= pidx_d;
            push_q  <= push_d;
            evt_q   <= evt_d;
            ctl_q   <= ctl_d;
            err_q   <= err_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_evt_t))
    ) u_fifo (
        .clk     (CLK),
        .srst    (RST),
        .push_i  (push_q),
        .wdata_i (evt_q),
        .pop_i   (evReady),
        .rdata_o (head),
        .full_o  (),
        .empty_o (fifo_empty),
        .ovf_o   (ovf)
    );

    assign evCode  = head.code;
    assign evBreak = head.brk;
    assign evExt   = head.ext;
    assign evPause = head.pause;
    assign evValid = !fifo_empty;
    assign ctlSeen = ctl_q;
    assign seqErr  = err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder (FIFO_DEPTH=4, PAUSE_EN=1, DROP_CTL=1).
module tb_ps2_scan_decoder;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] psCode;
    logic       dRdy;
    logic       clrDrdy;
    logic [7:0] evCode;
    logic       evBreak, evExt, evPause, evValid;
    logic       evReady;
    logic       ctlSeen, seqErr, ovf;

    int checks   = 0;
    int failures = 0;

    // Observations captured by send_byte
    int   ack_wait;
    logic clr_second;
    logic ctl_s;
    logic err_s;
    logic valid_mid;

    always #5 CLK = ~CLK;

    ps2_scan_decoder #(
        .FIFO_DEPTH (4),
        .PAUSE_EN   (1),
        .DROP_CTL   (1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .psCode  (psCode),
        .dRdy    (dRdy),
        .clrDrdy (clrDrdy),
        .evCode  (evCode),
        .evBreak (evBreak),
        .evExt   (evExt),
        .evPause (evPause),
        .evValid (evValid),
        .evReady (evReady),
        .ctlSeen (ctlSeen),
        .seqErr  (seqErr),
        .ovf     (ovf)
    );

    // Present one byte, release it on clrDrdy, return when the decoder is idle again
    task automatic send_byte(input logic [7:0] b);
        psCode   = b;
        dRdy     = 1'b1;
        ack_wait = 0;
        do begin
            @(posedge CLK); #1;
            ack_wait++;
        end while (!clrDrdy && ack_wait < 8);
        if (!clrDrdy) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout byte=%02h got clrDrdy=0 after %0d cycles, required 1", b, ack_wait);
        end
        dRdy = 1'b0;
        @(posedge CLK); #1;
        clr_second = clrDrdy;
        ctl_s      = ctlSeen;
        err_s      = seqErr;
        valid_mid  = evValid;
        @(posedge CLK); #1;
        $display("byte %02h ack_wait=%0d ctl=%0b err=%0b evValid=%0b", b, ack_wait, ctl_s, err_s, evValid);
    endtask

    // Read the head as presented, then pop it with a one-cycle evReady
    task automatic pop_head(output logic v, output logic [7:0] c, output logic br, output logic ex,
                            output logic pa);
        v  = evValid;
        c  = evCode;
        br = evBreak;
        ex = evExt;
        pa = evPause;
        evReady = 1'b1;
        @(posedge CLK); #1;
        evReady = 1'b0;
        $display("pop valid=%0b code=%02h brk=%0b ext=%0b pause=%0b", v, c, br, ex, pa);
    endtask

    task automatic test_reset();
        RST = 1'b1; dRdy = 1'b0; evReady = 1'b0; psCode = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({clrDrdy, evValid, evCode, evBreak, evExt, evPause, ctlSeen, seqErr, ovf} !== 16'h0) begin
            failures++;
            $display("FAIL reset_hold got %04h required 0000",
                     {clrDrdy, evValid, evCode, evBreak, evExt, evPause, ctlSeen, seqErr, ovf});
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if ({clrDrdy, evValid, evCode, evBreak, evExt, evPause, ctlSeen, seqErr, ovf} !== 16'h0) begin
            failures++;
            $display("FAIL reset_release got %04h required 0000",
                     {clrDrdy, evValid, evCode, evBreak, evExt, evPause, ctlSeen, seqErr, ovf});
        end
        $display("reset done");
    endtask

    task automatic test_make_break();
        logic v, br, ex, pa;
        logic [7:0] c;
        send_byte(8'h1C);
        checks++;
        if ({ack_wait, clr_second} !== {32'd1, 1'b0}) begin
            failures++;
            $display("FAIL clr_pulse got wait=%0d second=%0b required wait=1 second=0", ack_wait, clr_second);
        end
        checks++;
        if ({valid_mid, evValid} !== 2'b01) begin
            failures++;
            $display("FAIL event_latency got mid=%0b after=%0b required mid=0 after=1", valid_mid, evValid);
        end
        pop_head(v, c, br, ex, pa);
        checks++;
        if ({v, c, br, ex, pa} !== {1'b1, 8'h1C, 3'b000}) begin
            failures++;
            $display("FAIL make_1c got v=%0b %02h b%0b e%0b p%0b required v=1 1c b0 e0 p0", v, c, br, ex, pa);
        end
        send_byte(8'hF0);
        checks++;
        if (evValid !== 1'b0) begin
            failures++;
            $display("FAIL f0_no_event got evValid=%0b required 0", evValid);
        end
        send_byte(8'h1C);
        pop_head(v, c, br, ex, pa);
        checks++;
        if ({v, c, br, ex, pa} !== {1'b1, 8'h1C, 3'b100}) begin
            failures++;
            $display("FAIL break_1c got v=%0b %02h b%0b e%0b p%0b required v=1 1c b1 e0 p0", v, c, br, ex, pa);
        end
    endtask

    task automatic test_extended();
        logic v, br, ex, pa;
        logic [7:0] c;
        send_byte(8'hE0);
        send_byte(8'hF0);
        checks++;
        if (evValid !== 1'b0) begin
            failures++;
            $display("FAIL ext_prefix_no_event got evValid=%0b required 0", evValid);
        end
        send_byte(8'h75);
        pop_head(v, c, br, ex, pa);
        checks++;
        if ({v, c, br, ex, pa} !== {1'b1, 8'h75, 3'b110}) begin
            failures++;
            $display("FAIL ext_break_75 got v=%0b %02h b%0b e%0b p%0b required v=1 75 b1 e1 p0", v, c, br, ex, pa);
        end
        checks++;
        if (evValid !== 1'b0) begin
            failures++;
            $display("FAIL ext_single_event got evValid=%0b required 0", evValid);
        end
    endtask

    task automatic test_pause();
        logic v, br, ex, pa;
        logic [7:0] c;
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 7; i++) begin
            send_byte(seq[i]);
        end
        checks++;
        if ({evValid, err_s} !== 2'b00) begin
            failures++;
            $display("FAIL pause_partial got evValid=%0b err=%0b required 0 0", evValid, err_s);
        end
        send_byte(seq[7]);
        pop_head(v, c, br, ex, pa);
        checks++;
        if ({v, c, br, ex, pa} !== {1'b1, 8'hE1, 3'b001}) begin
            failures++;
            $display("FAIL pause_event got v=%0b %02h b%0b e%0b p%0b required v=1 e1 b0 e0 p1", v, c, br, ex, pa);
        end
        checks++;
        if (evValid !== 1'b0) begin
            failures++;
            $display("FAIL pause_single got evValid=%0b required 0", evValid);
        end
    endtask

    task automatic test_pause_error();
        logic v, br, ex, pa;
        logic [7:0] c;
        // Fifth byte corrupted (F0 replaced by 12); stop at the mismatching byte
        logic [7:0] seq [5] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'h12};
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i]);
        end
        checks++;
        if (err_s !== 1'b0) begin
            failures++;
            $display("FAIL pause_prefix_err got seqErr=%0b required 0", err_s);
        end
        send_byte(seq[4]);
        checks++;
        if ({err_s, evValid} !== 2'b10) begin
            failures++;
            $display("FAIL pause_mismatch got err=%0b evValid=%0b required 1 0", err_s, evValid);
        end
        checks++;
        if (seqErr !== 1'b0) begin
            failures++;
            $display("FAIL seqerr_pulse_width got seqErr=%0b required 0", seqErr);
        end
        send_byte(8'h1C);
        pop_head(v, c, br, ex, pa);
        checks++;
        if ({v, c, br, ex, pa} !== {1'b1, 8'h1C, 3'b000}) begin
            failures++;
            $display("FAIL after_pause_err got v=%0b %02h b%0b e%0b p%0b required v=1 1c b0 e0 p0", v, c, br, ex, pa);
        end
    endtask

    task automatic test_break_ext_error();
        logic v, br, ex, pa;
        logic [7:0] c;
        send_byte(8'hF0);
        send_byte(8'hE0);
        checks++;
        if ({err_s, evValid} !== 2'b10) begin
            failures++;
            $display("FAIL f0_e0_err got err=%0b evValid=%0b required 1 0", err_s, evValid);
        end
        send_byte(8'h1C);
        pop_head(v, c, br, ex, pa);
        checks++;
        if ({v, c, br, ex, pa} !== {1'b1, 8'h1C, 3'b000}) begin
            failures++;
            $display("FAIL after_f0_e0 got v=%0b %02h b%0b e%0b p%0b required v=1 1c b0 e0 p0", v, c, br, ex, pa);
        end
    endtask

    task automatic test_control();
        logic v, br, ex, pa;
        logic [7:0] c;
        send_byte(8'hFA);
        checks++;
        if ({ctl_s, err_s, evValid} !== 3'b100) begin
            failures++;
            $display("FAIL ctl_fa got ctl=%0b err=%0b evValid=%0b required 1 0 0", ctl_s, err_s, evValid);
        end
        checks++;
        if (ctlSeen !== 1'b0) begin
            failures++;
            $display("FAIL ctl_pulse_width got ctlSeen=%0b required 0", ctlSeen);
        end
        send_byte(8'hE0);
        send_byte(8'h00);
        checks++;
        if ({ctl_s, evValid} !== 2'b10) begin
            failures++;
            $display("FAIL ctl_00 got ctl=%0b evValid=%0b required 1 0", ctl_s, evValid);
        end
        send_byte(8'h1C);
        pop_head(v, c, br, ex, pa);
        checks++;
        if ({v, c, br, ex, pa} !== {1'b1, 8'h1C, 3'b000}) begin
            failures++;
            $display("FAIL ctl_00_clears_ext got v=%0b %02h b%0b e%0b p%0b required v=1 1c b0 e0 p0", v, c, br, ex, pa);
        end
    endtask

    task automatic test_overflow();
        logic v, br, ex, pa;
        logic [7:0] c;
        logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        for (int i = 0; i < 4; i++) begin
            send_byte(codes[i]);
        end
        checks++;
        if ({evValid, ovf} !== 2'b10) begin
            failures++;
            $display("FAIL fifo_fill got evValid=%0b ovf=%0b required 1 0", evValid, ovf);
        end
        send_byte(codes[4]);
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL fifo_ovf got ovf=%0b required 1", ovf);
        end
        for (int i = 0; i < 4; i++) begin
            pop_head(v, c, br, ex, pa);
            checks++;
            if ({v, c, br, ex, pa} !== {1'b1, codes[i], 3'b000}) begin
                failures++;
                $display("FAIL drain_%0d got v=%0b %02h b%0b e%0b p%0b required v=1 %02h b0 e0 p0",
                         i, v, c, br, ex, pa, codes[i]);
            end
        end
        checks++;
        if (evValid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty got evValid=%0b required 0", evValid);
        end
    endtask

    task automatic test_back_to_back();
        logic v, br, ex, pa;
        logic [7:0] c;
        logic [7:0] codes [5] = '{8'h43, 8'h44, 8'h4B, 8'h4C, 8'h4D};
        for (int i = 0; i < 4; i++) begin
            send_byte(codes[i]);
        end
        // Fifth code: pop the head exactly on the edge where the new event is pushed
        psCode = codes[4];
        dRdy   = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (clrDrdy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ack got clrDrdy=%0b required 1", clrDrdy);
        end
        dRdy = 1'b0;
        @(posedge CLK); #1;
        evReady = 1'b1;
        @(posedge CLK); #1;
        evReady = 1'b0;
        $display("push with pop on full fifo, code %02h", codes[4]);
        for (int i = 1; i < 5; i++) begin
            pop_head(v, c, br, ex, pa);
            checks++;
            if ({v, c, br, ex, pa} !== {1'b1, codes[i], 3'b000}) begin
                failures++;
                $display("FAIL b2b_drain_%0d got v=%0b %02h b%0b e%0b p%0b required v=1 %02h b0 e0 p0",
                         i, v, c, br, ex, pa, codes[i]);
            end
        end
        checks++;
        if (evValid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_empty got evValid=%0b required 0", evValid);
        end
    endtask

    task automatic test_reset_midstream();
        logic v, br, ex, pa;
        logic [7:0] c;
        // Queued event plus a partial Pause sequence, then reset
        send_byte(8'h1C);
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checks++;
        if ({clrDrdy, evValid, evCode, evBreak, evExt, evPause, ctlSeen, seqErr, ovf} !== 16'h0) begin
            failures++;
            $display("FAIL mid_reset got %04h required 0000",
                     {clrDrdy, evValid, evCode, evBreak, evExt, evPause, ctlSeen, seqErr, ovf});
        end
        send_byte(8'h1C);
        checks++;
        if (err_s !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_pause_cleared got seqErr=%0b required 0", err_s);
        end
        pop_head(v, c, br, ex, pa);
        checks++;
        if ({v, c, br, ex, pa} !== {1'b1, 8'h1C, 3'b000}) begin
            failures++;
            $display("FAIL mid_reset_1c got v=%0b %02h b%0b e%0b p%0b required v=1 1c b0 e0 p0", v, c, br, ex, pa);
        end
        // Prefixes pending at reset must be discarded
        send_byte(8'hE0);
        send_byte(8'hF0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        send_byte(8'h1C);
        pop_head(v, c, br, ex, pa);
        checks++;
        if ({v, c, br, ex, pa} !== {1'b1, 8'h1C, 3'b000}) begin
            failures++;
            $display("FAIL prefix_reset_1c got v=%0b %02h b%0b e%0b p%0b required v=1 1c b0 e0 p0", v, c, br, ex, pa);
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_pause();
        test_pause_error();
        test_break_ext_error();
        test_control();
        test_overflow();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout got no completion required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
